// File: rtl/sc_nadder_ctrl_if.sv
// Handshake and stream bus between a host, the sc_nadder datapath and its sequencer.
// The sequencer takes the slave modport.
interface sc_nadder_ctrl_if #(
   parameter int SELECT_WIDTH = 3,
   parameter int LEN_WIDTH    = 8
);
   logic                    start;
   logic [LEN_WIDTH-1:0]    length;
   logic                    mode;
   logic [7:0]              seed;
   logic                    nadder_out;
   logic [SELECT_WIDTH-1:0] sel;
   logic                    stream_valid;
   logic [LEN_WIDTH-1:0]    count;
   logic                    busy;
   logic                    done;

   modport master (
      output start, length, mode, seed, nadder_out,
      input  sel, stream_valid, count, busy, done
   );

   modport slave (
      input  start, length, mode, seed, nadder_out,
      output sel, stream_valid, count, busy, done
   );
endinterface

// File: rtl/sc_nadder_ctrl.sv
// Sequencer for the stochastic n-input scaled adder: walks the select bus for a run of
// programmable length, round-robin or LFSR, and counts the ones on the adder output.
module sc_nadder_ctrl #(
   parameter int INPUT_STREAMS = 8,
   parameter int SELECT_WIDTH  = 3,
   parameter int LEN_WIDTH     = 8
) (
   input logic             clk,
   input logic             rst,
   sc_nadder_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic [LEN_WIDTH-1:0]    rem_r, rem_s;
   logic [LEN_WIDTH-1:0]    count_r, count_s;
   logic [7:0]              lfsr_r, lfsr_s;
   logic                    mode_r, mode_s;
   logic [SELECT_WIDTH-1:0] sel_r, sel_s;
   logic                    valid_r, busy_r, done_r;

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
   function automatic logic [7:0] seed_fix(input logic [7:0] s);
      return (s == 8'h00) ? 8'h01 : s;
   endfunction

   // Next-state, run bookkeeping and the select value for the coming cycle
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      count_s = count_r;
      lfsr_s  = lfsr_r;
      mode_s  = mode_r;
      sel_s   = {SELECT_WIDTH{1'b0}};
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               mode_s  = bus.mode;
               lfsr_s  = seed_fix(bus.seed);
               rem_s   = bus.length;
               count_s = {LEN_WIDTH{1'b0}};
               if (bus.length != {LEN_WIDTH{1'b0}}) begin
                  state_s = RUN;
                  sel_s   = bus.mode ? lfsr_s[SELECT_WIDTH-1:0] : {SELECT_WIDTH{1'b0}};
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            count_s = count_r + LEN_WIDTH'(bus.nadder_out);
            rem_s   = rem_r - LEN_WIDTH'(1);
            lfsr_s  = lfsr_next(lfsr_r);
            if (rem_r == LEN_WIDTH'(1)) begin
               state_s = DONE;
            end else if (mode_r) begin
               state_s = RUN;
               sel_s   = lfsr_s[SELECT_WIDTH-1:0];
            end else begin
               state_s = RUN;
               sel_s   = (sel_r == SELECT_WIDTH'(INPUT_STREAMS - 1)) ?
                         {SELECT_WIDTH{1'b0}} : sel_r + SELECT_WIDTH'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register, run bookkeeping and registered outputs decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         rem_r   <= {LEN_WIDTH{1'b0}};
         count_r <= {LEN_WIDTH{1'b0}};
         lfsr_r  <= 8'h01;
         mode_r  <= 1'b0;
         sel_r   <= {SELECT_WIDTH{1'b0}};
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         rem_r   <= rem_s;
         count_r <= count_s;
         lfsr_r  <= lfsr_s;
         mode_r  <= mode_s;
         sel_r   <= sel_s;
         valid_r <= (state_s == RUN);
         busy_r  <= (state_s != IDLE);
         done_r  <= (state_s == DONE);
      end
   end

   assign bus.sel          = sel_r;
   assign bus.stream_valid = valid_r;
   assign bus.count        = count_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
endmodule
